// File: rtl/cla_mp_seq.sv
// cla_mp_seq: multi-precision adder, one 5-bit CLA word per cycle, LSB first.
// Optional subtract mode is enabled by defining CLA_MP_SUB_EN (adds port sub).

module cla5_slice (
    input  logic [4:0] a_i,
    input  logic [4:0] b_i,
    input  logic       c_i,
    output logic [4:0] s_o,
    output logic       c_o
);

    logic [4:0] p;
    logic [4:0] g_bar;
    logic [5:0] c;
    logic       acc;
    logic       pp;

    assign p     = a_i ^ b_i;
    assign g_bar = ~(a_i & b_i);

    // c[i+1] = NAND of g_bar[i] and NAND(p[i..j], g[j-1]) lookahead terms
    always_comb begin
        c    = '0;
        acc  = 1'b1;
        pp   = 1'b1;
        c[0] = c_i;
        for (int i = 0; i < 5; i++) begin
            acc = g_bar[i];
            pp  = 1'b1;
            for (int j = i; j > 0; j--) begin
                pp  = pp & p[j];
                acc = acc & ~(pp & ~g_bar[j-1]);
            end
            pp     = pp & p[0];
            acc    = acc & ~(pp & c_i);
            c[i+1] = ~acc;
        end
    end

    assign s_o = p ^ c[4:0];
    assign c_o = c[5];

endmodule

module cla_mp_seq #(
    parameter  int NWORDS = 4,
    localparam int W      = 5 * NWORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef CLA_MP_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          sub_q, sub_d;
    logic          sub_in;

    logic [4:0]    aw;
    logic [4:0]    bw;
    logic [4:0]    s;
    logic          co;

`ifdef CLA_MP_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        aw = '0;
        bw = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (idx_q == IW'(w)) begin
                aw = a_q[5*w +: 5];
                bw = b_q[5*w +: 5];
            end
        end
    end

    cla5_slice u_slice (
        .a_i (aw),
        .b_i (bw ^ {5{sub_q}}),
        .c_i (carry_q),
        .s_o (s),
        .c_o (co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        sub_d   = sub_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_in;
                    carry_d = sub_in ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int w = 0; w < NWORDS; w++) begin
                    if (idx_q == IW'(w)) begin
                        sum_d[5*w +: 5] = s;
                    end
                end
                carry_d = co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NWORDS - 1)) begin
                    cout_d  = co;
                    idx_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
        end
    end

    assign in_ready  = rst_n & (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_mp_seq.sv
// tb_cla_mp_seq: directed vectors for cla_mp_seq with NWORDS=4 and NWORDS=1.
// Define CLA_MP_SUB_EN to also exercise the subtract mode.

module tb_cla_mp_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4;
    logic        cout4, busy4, sub4;
    logic [19:0] a4, b4, sum4;

    logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1;
    logic        cout1, busy1, sub1;
    logic [4:0]  a1, b1, sum1;

    cla_mp_seq #(.NWORDS(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
`ifdef CLA_MP_SUB_EN
        .sub       (sub4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4)
    );

    cla_mp_seq #(.NWORDS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef CLA_MP_SUB_EN
        .sub       (sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [19:0] a;
        logic [19:0] b;
        logic        cin;
        logic [19:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic job4(input logic [19:0] ta, input logic [19:0] tb,
                        input logic tc, output int lat, output int runb);
        check("in_ready4_before_job", in_ready4, 1);
        a4        = ta;
        b4        = tb;
        cin4      = tc;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        lat       = 0;
        runb      = 0;
        while (!out_valid4 && lat < 20) begin
            runb += int'(busy4);
            step();
            lat++;
        end
    endtask

    task automatic release4();
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        check("rel4_out_valid", out_valid4, 0);
        check("rel4_in_ready", in_ready4, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int runb;
        int bad;

        vecs[0] = '{20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1};
        vecs[1] = '{20'h12345, 20'h0ABCD, 1'b1, 20'h1CF13, 1'b0};
        vecs[2] = '{20'h00003, 20'h00004, 1'b0, 20'h00007, 1'b0};
        vecs[3] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1};
        vecs[4] = '{20'h00000, 20'h00000, 1'b1, 20'h00001, 1'b0};
        vecs[5] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1};
        vecs[6] = '{20'h0F0F0, 20'h00F0F, 1'b0, 20'h0FFFF, 1'b0};
        vecs[7] = '{20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0};
        vecs[8] = '{20'hAAAAA, 20'h55555, 1'b1, 20'h00000, 1'b1};

        rst_n      = 1'b0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        a4         = '0;
        b4         = '0;
        cin4       = 1'b0;
        sub4       = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        sub1       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_sum4", sum4, 0);
        check("rst_cout4", cout4, 0);
        check("rst_out_valid4", out_valid4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_sum1", sum1, 0);
        check("rst_out_valid1", out_valid1, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready4", in_ready4, 1);
        check("post_rst_in_ready1", in_ready1, 1);

        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        check("idle_out_ready_busy", busy4, 0);
        check("idle_out_ready_valid", out_valid4, 0);

        for (int i = 0; i < 9; i++) begin
            job4(vecs[i].a, vecs[i].b, vecs[i].cin, lat, runb);
            check($sformatf("v%0d_latency", i), lat, 4);
            check($sformatf("v%0d_run_busy", i), runb, 4);
            check($sformatf("v%0d_hold_busy", i), busy4, 1);
            check($sformatf("v%0d_sum", i), sum4, vecs[i].s);
            check($sformatf("v%0d_cout", i), cout4, vecs[i].co);
            release4();
        end

        job4(20'h12345, 20'h0ABCD, 1'b1, lat, runb);
        check("bp_latency", lat, 4);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid4 = ~in_valid4;
            a4        = 20'($urandom);
            b4        = 20'($urandom);
            step();
            if (sum4 !== 20'h1CF13 || cout4 !== 1'b0 ||
                out_valid4 !== 1'b1 || in_ready4 !== 1'b0)
                bad++;
        end
        in_valid4 = 1'b0;
        check("bp_stable_cycles_bad", bad, 0);
        release4();
        check("bp_sum_retained", sum4, 20'h1CF13);
        check("bp_cout_retained", cout4, 0);

        a4        = 20'h12345;
        b4        = 20'h0ABCD;
        cin4      = 1'b1;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        step();
        step();
        check("mid_run_busy", busy4, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", sum4, 0);
        check("mid_rst_cout", cout4, 0);
        check("mid_rst_out_valid", out_valid4, 0);
        check("mid_rst_busy", busy4, 0);
        #2;
        rst_n = 1'b1;
        step();
        check("after_rst_in_ready", in_ready4, 1);
        check("after_rst_out_valid", out_valid4, 0);
        job4(20'h00003, 20'h00004, 1'b0, lat, runb);
        check("after_rst_latency", lat, 4);
        check("after_rst_sum", sum4, 20'h00007);
        check("after_rst_cout", cout4, 0);
        release4();

`ifdef CLA_MP_SUB_EN
        sub4 = 1'b1;
        job4(20'h00005, 20'h00007, 1'b0, lat, runb);
        check("sub1_latency", lat, 4);
        check("sub1_sum", sum4, 20'hFFFFE);
        check("sub1_cout", cout4, 0);
        release4();
        job4(20'h00007, 20'h00005, 1'b1, lat, runb);
        check("sub2_sum", sum4, 20'h00002);
        check("sub2_cout", cout4, 1);
        release4();
        sub4 = 1'b0;
        job4(20'h00005, 20'h00007, 1'b0, lat, runb);
        check("sub0_sum", sum4, 20'h0000C);
        release4();
`endif

        check("n1_in_ready", in_ready1, 1);
        a1        = 5'h1F;
        b1        = 5'h01;
        cin1      = 1'b0;
        in_valid1 = 1'b1;
        step();
        a1  = 5'h03;
        b1  = 5'h04;
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            step();
            lat++;
        end
        check("n1_latency", lat, 1);
        check("n1_sum", sum1, 5'h00);
        check("n1_cout", cout1, 1);
        check("n1_hold_in_ready", in_ready1, 0);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("n1_hs_out_valid", out_valid1, 0);
        check("n1_hs_busy", busy1, 0);
        check("n1_hs_in_ready", in_ready1, 1);
        step();
        in_valid1 = 1'b0;
        check("n1_second_accept_busy", busy1, 1);
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            step();
            lat++;
        end
        check("n1_second_latency", lat, 1);
        check("n1_second_sum", sum1, 5'h07);
        check("n1_second_cout", cout1, 0);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;

        a1        = 5'h1F;
        b1        = 5'h1F;
        cin1      = 1'b1;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        lat       = 0;
        while (!out_valid1 && lat < 10) begin
            step();
            lat++;
        end
        check("n1_third_sum", sum1, 5'h1F);
        check("n1_third_cout", cout1, 1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
